// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state encoding and op codes for the shared-alu arbiter
package alu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd4;
endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-way round-robin arbiter, favours the requester not granted last
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       acc,
  output logic [1:0] gnt
);
  logic last_q;
  assign gnt[0] = req[0] & (~req[1] | last_q);
  assign gnt[1] = req[1] & (~req[0] | ~last_q);
  // remember the winner only when the grant is actually taken
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else if (acc) last_q <= gnt[1];
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external alu between two requesters with a 3-state handshake
import alu_ctrl_pkg::*;
module alu_share_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_f,
  input  logic [3:0]  req1_f,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_f,
  input  logic [31:0] alu_r,
  output logic        busy,
  output logic [15:0] op_count
);
  state_t      state_q, state_d;
  logic [1:0]  gnt;
  logic        acc, hs;
  logic [31:0] a_q, b_q, r_q;
  logic [3:0]  f_q;
  logic        id_q, err_q;
  logic [15:0] cnt_q;
  alu_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .req({req1_valid, req0_valid}),
    .acc(acc),
    .gnt(gnt)
  );
  // accept only from IDLE, held off while in reset so every output reads 0
  always_comb begin
    acc = (state_q == IDLE) & (|gnt) & ~rst;
    hs = (state_q == RESP) & rsp_ready;
    state_d = acc ? EXEC : (state_q == EXEC) ? RESP : hs ? IDLE : state_q;
  end
  // state, operand, result and counter registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
      id_q <= 1'b0;
      r_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        a_q <= gnt[1] ? req1_a : req0_a;
        b_q <= gnt[1] ? req1_b : req0_b;
        f_q <= gnt[1] ? req1_f : req0_f;
        id_q <= gnt[1];
      end
      if (state_q == EXEC) begin
        err_q <= f_q[3:1] > OP_MAX;
        r_q <= (f_q[3:1] > OP_MAX) ? '0 : alu_r;
      end
      if (hs && !err_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  assign req0_ready = acc & gnt[0];
  assign req1_ready = acc & gnt[1];
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_r = r_q;
  assign rsp_err = err_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_f = f_q;
  assign busy = state_q != IDLE;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench with an external alu model
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [3:0]  req0_f = '0, req1_f = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
  logic [31:0] rsp_r, alu_a, alu_b, alu_r, bb;
  logic [3:0]  alu_f;
  logic [15:0] op_count;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  alu_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_f(req0_f), .req1_f(req1_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_r(alu_r),
    .busy(busy), .op_count(op_count)
  );
  always_comb begin
    bb = alu_f[0] ? 32'd1 : alu_b;
    alu_r = (alu_f[3:1] == 3'd0) ? alu_a + bb :
            (alu_f[3:1] == 3'd1) ? alu_a - bb :
            (alu_f[3:1] == 3'd2) ? 32'(alu_a[15:0]) * 32'(alu_b[15:0]) :
            (alu_f[3:1] == 3'd3) ? alu_a >> alu_b[4:0] :
            (alu_f[3:1] == 3'd4) ? alu_a << alu_b[4:0] : 32'd0;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask
  task automatic single(input bit n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic [31:0] er, input bit ee);
    rsp_ready = 1'b1;
    if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f; end
    else begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f; end
    #1;
    chk("single_ready", {req1_ready, req0_ready}, n ? 2 : 1);
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("single_exec_busy", busy, 1);
    chk("single_exec_rsp_valid", rsp_valid, 0);
    step;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_r", rsp_r, er);
    chk("single_rsp_id", rsp_id, n);
    chk("single_rsp_err", rsp_err, ee);
    step;
    chk("single_done_valid", rsp_valid, 0);
  endtask
  initial begin
    step;
    step;
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_r", rsp_r, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_f", alu_f, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    rst = 1'b0;
    single(0, 32'd5, 32'd7, 4'b0000, 32'd12, 0);
    chk("add_op_count", op_count, 1);
    do_reset;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd9; req0_f = 4'b0001;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_f = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    chk("both_first_ready", {req1_ready, req0_ready}, 1);
    step;
    req0_valid = 1'b0;
    #1;
    chk("both_exec_ready", {req1_ready, req0_ready}, 0);
    chk("both_exec_alu_a", alu_a, 5);
    step;
    chk("both_r0", rsp_r, 6);
    chk("both_id0", rsp_id, 0);
    step;
    chk("both_second_ready", {req1_ready, req0_ready}, 2);
    step;
    req1_valid = 1'b0;
    step;
    chk("both_r1", rsp_r, 7);
    chk("both_id1", rsp_id, 1);
    step;
    chk("both_op_count", op_count, 2);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_f = 4'b0100;
    step;
    req0_valid = 1'b0;
    step;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_f = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_r", rsp_r, 12);
      chk("hold_id", rsp_id, 0);
      chk("hold_ready", {req1_ready, req0_ready}, 0);
      chk("hold_busy", busy, 1);
      step;
    end
    rsp_ready = 1'b1;
    step;
    chk("hold_op_count", op_count, 3);
    chk("err_ready", {req1_ready, req0_ready}, 2);
    step;
    req1_valid = 1'b0;
    step;
    chk("err_flag", rsp_err, 1);
    chk("err_r", rsp_r, 0);
    chk("err_id", rsp_id, 1);
    step;
    chk("err_op_count", op_count, 3);
    single(0, 32'd1, 32'd31, 4'b1000, 32'h8000_0000, 0);
    single(1, 32'h80, 32'd4, 4'b0110, 32'd8, 0);
    chk("shift_op_count", op_count, 5);
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 4'b0000;
    step;
    req0_valid = 1'b0;
    #1;
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    step;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_op_count", op_count, 0);
    rst = 1'b0;
    step;
    step;
    chk("abort_no_rsp", rsp_valid, 0);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_f = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'h80; req1_b = 32'd4; req1_f = 4'b0110;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_ready", {req1_ready, req0_ready}, (i % 2) ? 2 : 1);
      step;
      step;
      chk("rr_r", rsp_r, (i % 2) ? 8 : 101);
      chk("rr_id", rsp_id, i % 2);
      step;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_op_count", op_count, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
